// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor with valid/ready
// handshake and full backpressure. The WIDTH-bit operation is split into
// STAGES chunks of WIDTH/STAGES bits. One chunk is resolved per cycle, and
// the carry is registered between chunks.
//
// Pipeline layout:
//   level 0           : captured operands (B already conditioned by ctr),
//                       carry-in = ctr, no sum bits resolved yet.
//   level k+1         : stage k has resolved chunk k. Lower sum bits travel
//                       forward together with the operands that are still
//                       needed by the upper chunks.
//   level STAGES      : output register (s, co, ov, z, n, out_valid).
// An operation accepted at edge t therefore presents out_valid after edge
// t+STAGES.
//
// Any stall (out_valid && !out_ready) freezes every level at once. The only
// backpressure path is therefore the single combinational in_ready = !stall.
//
// WIDTH must be a multiple of STAGES, and STAGES must be in 1..WIDTH.

module addsub_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ctr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov,
   output logic             z,
   output logic             n
);

   // Bits resolved by each stage.
   localparam int CW = WIDTH / STAGES;

   logic             stall;

   // Per-level valid bit, carry into the next unresolved chunk, and partial sum.
   logic             v_reg  [0:STAGES];
   logic             c_reg  [0:STAGES];
   logic [WIDTH-1:0] s_reg  [0:STAGES];

   // Operands only exist up to the last computing stage. B is stored
   // already XORed with ctr, so a subtract is simply an add with carry-in 1.
   logic [WIDTH-1:0] a_reg  [0:STAGES-1];
   logic [WIDTH-1:0] bx_reg [0:STAGES-1];

   // Flags that are produced only by the final stage.
   logic             ov_reg;
   logic             z_reg;
   logic             n_reg;

   assign stall     = v_reg[STAGES] && !out_ready;
   assign in_ready  = !stall;

   assign out_valid = v_reg[STAGES];
   assign s         = s_reg[STAGES];
   assign co        = c_reg[STAGES];
   assign ov        = ov_reg;
   assign z         = z_reg;
   assign n         = n_reg;

   // Operand capture: while the pipeline is not stalled, take a new operand
   // set (or a bubble) every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_reg[0]  <= 1'b0;
         c_reg[0]  <= 1'b0;
         s_reg[0]  <= '0;
         a_reg[0]  <= '0;
         bx_reg[0] <= '0;
      end else if (!stall) begin
         v_reg[0]  <= in_valid;
         c_reg[0]  <= ctr;
         s_reg[0]  <= '0;
         a_reg[0]  <= a;
         bx_reg[0] <= b ^ {WIDTH{ctr}};
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage

      logic [CW:0]      sum_next;
      logic [WIDTH-1:0] s_next;

      // Chunk gi of A + (B ^ ctr) + carry-in.
      // The extra top bit of sum_next is the chunk carry-out.
      assign sum_next = {1'b0, a_reg[gi][gi*CW +: CW]}
                      + {1'b0, bx_reg[gi][gi*CW +: CW]}
                      + {{CW{1'b0}}, c_reg[gi]};

      // Merge the newly resolved chunk into the partial sum that arrived from
      // the lower stages.
      always_comb begin
         s_next                = s_reg[gi];
         s_next[gi*CW +: CW]   = sum_next[CW-1:0];
      end

      if (gi < STAGES-1) begin : g_mid

         // Intermediate stage: advance the operation, the carry and the
         // partial sum by one level.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_reg[gi+1]  <= 1'b0;
               c_reg[gi+1]  <= 1'b0;
               s_reg[gi+1]  <= '0;
               a_reg[gi+1]  <= '0;
               bx_reg[gi+1] <= '0;
            end else if (!stall) begin
               v_reg[gi+1]  <= v_reg[gi];
               c_reg[gi+1]  <= sum_next[CW];
               s_reg[gi+1]  <= s_next;
               a_reg[gi+1]  <= a_reg[gi];
               bx_reg[gi+1] <= bx_reg[gi];
            end
         end

      end else begin : g_last

         logic msb_cin;

         // The carry into the MSB is recovered from the MSB's own sum bit:
         // s = a ^ b ^ cin.
         assign msb_cin = a_reg[gi][WIDTH-1] ^ bx_reg[gi][WIDTH-1] ^ s_next[WIDTH-1];

         // Final stage: register the result and its flags. A bubble leaves
         // the previous result in place.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               v_reg[STAGES] <= 1'b0;
               c_reg[STAGES] <= 1'b0;
               s_reg[STAGES] <= '0;
               ov_reg        <= 1'b0;
               z_reg         <= 1'b0;
               n_reg         <= 1'b0;
            end else if (!stall) begin
               v_reg[STAGES] <= v_reg[gi];
               if (v_reg[gi]) begin
                  c_reg[STAGES] <= sum_next[CW];
                  s_reg[STAGES] <= s_next;
                  ov_reg        <= msb_cin ^ sum_next[CW];
                  z_reg         <= ~|s_next;
                  n_reg         <= s_next[WIDTH-1];
               end
            end
         end

      end
   end

endmodule

// File: tb/tb_addsub_pipe.sv
// Testbench for addsub_pipe. Three instances are checked side by side:
//   dut0: WIDTH=32, STAGES=4
//   dut1: WIDTH=32, STAGES=1
//   dut2: WIDTH=16, STAGES=2
// Expected results come from a plain-arithmetic reference model.

module tb_addsub_pipe;

   localparam int ND = 3;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n     [ND];
   logic        in_valid  [ND];
   logic        in_ready  [ND];
   logic        out_valid [ND];
   logic        out_ready [ND];
   logic        ctr       [ND];
   logic        co        [ND];
   logic        ov        [ND];
   logic        z         [ND];
   logic        n         [ND];
   logic [31:0] a         [ND];
   logic [31:0] b         [ND];
   logic [31:0] s         [ND];
   logic [15:0] s16;

   int checks = 0;
   int fails  = 0;

   addsub_pipe #(.WIDTH(32), .STAGES(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a[0]), .b(b[0]), .ctr(ctr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .s(s[0]), .co(co[0]), .ov(ov[0]), .z(z[0]), .n(n[0]));

   addsub_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a[1]), .b(b[1]), .ctr(ctr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .s(s[1]), .co(co[1]), .ov(ov[1]), .z(z[1]), .n(n[1]));

   addsub_pipe #(.WIDTH(16), .STAGES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a[2][15:0]), .b(b[2][15:0]), .ctr(ctr[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .s(s16), .co(co[2]), .ov(ov[2]), .z(z[2]), .n(n[2]));

   assign s[2] = {16'h0000, s16};

   function automatic int wid(input int d);
      return (d == 2) ? 16 : 32;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 2);
   endfunction

   // Reference model: integer arithmetic on the operand values.
   // rf = {co, ov, z, n}.
   function automatic void model(input int w, input logic [31:0] xa, input logic [31:0] xb,
                                 input logic xc, output logic [31:0] rs, output logic [3:0] rf);
      longint m, half, ua, ub, sa, sb, full, sr;
      m    = longint'(1) << w;
      half = m >> 1;
      ua   = longint'(xa) & (m - 1);
      ub   = longint'(xb) & (m - 1);
      sa   = (ua >= half) ? ua - m : ua;
      sb   = (ub >= half) ? ub - m : ub;
      if (!xc) begin
         full  = ua + ub;
         sr    = sa + sb;
         rf[3] = (full >= m);
      end else begin
         full  = ua - ub;
         sr    = sa - sb;
         rf[3] = (ua >= ub);
      end
      full  = full & (m - 1);
      rs    = full[31:0];
      rf[2] = (sr >= half) || (sr < -half);
      rf[1] = (full == 0);
      rf[0] = ((full >> (w - 1)) & 1) != 0;
   endfunction

   // Directed vectors with their expected 32-bit results.
   logic [31:0] dir_a [6] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h80000000, 32'h12345678};
   logic [31:0] dir_b [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007, 32'h00000001, 32'h12345678};
   logic        dir_c [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic [31:0] dir_s [6] = '{32'h00010000, 32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000000};
   logic [3:0]  dir_f [6] = '{4'b0000, 4'b1010, 4'b0101, 4'b0001, 4'b1100, 4'b1010};

   task automatic test_reset(input int d);
      checks++;
      if (out_valid[d] !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid dut%0d: got %b want 0", d, out_valid[d]);
      end
      checks++;
      if (in_ready[d] !== 1'b1) begin
         fails++; $display("FAIL reset_in_ready dut%0d: got %b want 1", d, in_ready[d]);
      end
      checks++;
      if (s[d] !== 32'h0) begin
         fails++; $display("FAIL reset_s dut%0d: got %h want 0", d, s[d]);
      end
      checks++;
      if ({co[d], ov[d], z[d], n[d]} !== 4'b0000) begin
         fails++; $display("FAIL reset_flags dut%0d: got %b want 0000", d, {co[d], ov[d], z[d], n[d]});
      end
      $display("dut%0d reset state checked", d);
   endtask

   task automatic test_directed(input int d);
      logic [31:0] es;
      logic [3:0]  ef;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         out_ready[d] = 1'b1;
         in_valid[d]  = 1'b1;
         a[d]         = dir_a[i];
         b[d]         = dir_b[i];
         ctr[d]       = dir_c[i];
         @(posedge clk);
         @(negedge clk);
         in_valid[d] = 1'b0;
         lat = 0;
         while (out_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         model(wid(d), dir_a[i], dir_b[i], dir_c[i], es, ef);
         $display("dut%0d op a=%h b=%h ctr=%b -> s=%h cozn=%b%b%b%b lat=%0d", d, dir_a[i], dir_b[i],
                  dir_c[i], s[d], co[d], ov[d], z[d], n[d], lat);
         checks++;
         if (lat != lat_of(d)) begin
            fails++; $display("FAIL dir_latency dut%0d vec%0d: got %0d want %0d", d, i, lat, lat_of(d));
         end
         checks++;
         if (s[d] !== es) begin
            fails++; $display("FAIL dir_s dut%0d vec%0d: got %h want %h", d, i, s[d], es);
         end
         checks++;
         if ({co[d], ov[d], z[d], n[d]} !== ef) begin
            fails++; $display("FAIL dir_flags dut%0d vec%0d: got %b want %b", d, i, {co[d], ov[d], z[d], n[d]}, ef);
         end
         if (d == 0) begin
            checks++;
            if (s[d] !== dir_s[i] || {co[d], ov[d], z[d], n[d]} !== dir_f[i]) begin
               fails++; $display("FAIL dir_const dut0 vec%0d: got %h/%b want %h/%b", i, s[d],
                                 {co[d], ov[d], z[d], n[d]}, dir_s[i], dir_f[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back(input int d);
      logic [31:0] oa [8];
      logic [31:0] ob [8];
      logic        oc [8];
      logic [31:0] exp_s [$];
      logic [3:0]  exp_f [$];
      logic [31:0] es, held_s;
      logic [3:0]  ef, held_f;
      logic        held;
      logic        want_ready;
      int          sent, got, cyc, stall_left, extra;

      for (int i = 0; i < 8; i++) begin
         oa[i] = $urandom;
         ob[i] = $urandom;
         oc[i] = 1'($urandom_range(0, 1));
      end
      sent = 0; got = 0; cyc = 0; stall_left = 0; held = 1'b0;
      held_s = '0; held_f = '0;
      while (got < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         out_ready[d] = (stall_left > 0) ? 1'b0 : 1'b1;
         if (stall_left > 0) stall_left--;
         in_valid[d] = (sent < 8);
         if (sent < 8) begin
            a[d] = oa[sent]; b[d] = ob[sent]; ctr[d] = oc[sent];
         end
         #1;
         if (held) begin
            checks++;
            if (out_valid[d] !== 1'b1 || s[d] !== held_s || {co[d], ov[d], z[d], n[d]} !== held_f) begin
               fails++; $display("FAIL b2b_hold dut%0d: got v=%b %h/%b want v=1 %h/%b", d, out_valid[d],
                                 s[d], {co[d], ov[d], z[d], n[d]}, held_s, held_f);
            end
         end
         want_ready = !(out_valid[d] === 1'b1 && out_ready[d] == 1'b0);
         checks++;
         if (in_ready[d] !== want_ready) begin
            fails++; $display("FAIL b2b_in_ready dut%0d cyc%0d: got %b want %b", d, cyc, in_ready[d], want_ready);
         end
         if (out_valid[d] === 1'b1 && out_ready[d]) begin
            checks++;
            if (exp_s.size() == 0) begin
               fails++; $display("FAIL b2b_extra dut%0d: got result %h want none", d, s[d]);
            end else begin
               es = exp_s.pop_front();
               ef = exp_f.pop_front();
               $display("dut%0d result %0d s=%h cozn=%b%b%b%b", d, got, s[d], co[d], ov[d], z[d], n[d]);
               if (s[d] !== es || {co[d], ov[d], z[d], n[d]} !== ef) begin
                  fails++; $display("FAIL b2b_result dut%0d #%0d: got %h/%b want %h/%b", d, got, s[d],
                                    {co[d], ov[d], z[d], n[d]}, es, ef);
               end
            end
            got++;
            if (got == 2) stall_left = 3;
         end
         held   = (out_valid[d] === 1'b1) && !out_ready[d];
         held_s = s[d];
         held_f = {co[d], ov[d], z[d], n[d]};
         if (in_valid[d] && in_ready[d] === 1'b1) begin
            model(wid(d), oa[sent], ob[sent], oc[sent], es, ef);
            exp_s.push_back(es);
            exp_f.push_back(ef);
            sent++;
         end
      end
      @(negedge clk);
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      checks++;
      if (got != 8 || exp_s.size() != 0) begin
         fails++; $display("FAIL b2b_count dut%0d: got %0d results (%0d pending) want 8 (0)", d, got, exp_s.size());
      end
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid[d] === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         fails++; $display("FAIL b2b_duplicate dut%0d: got %0d extra valid cycles want 0", d, extra);
      end
   endtask

   task automatic test_flush(input int d);
      logic [31:0] es;
      logic [3:0]  ef;
      int          lat, seen;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_ready[d] = 1'b1;
         in_valid[d]  = 1'b1;
         a[d]   = $urandom | 32'h1;
         b[d]   = $urandom;
         ctr[d] = 1'b0;
      end
      @(negedge clk);
      in_valid[d] = 1'b0;
      rst_n[d]    = 1'b0;
      @(negedge clk);
      rst_n[d] = 1'b1;
      #1;
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
         fails++; $display("FAIL flush_handshake dut%0d: got v=%b r=%b want v=0 r=1", d, out_valid[d], in_ready[d]);
      end
      checks++;
      if (s[d] !== 32'h0 || {co[d], ov[d], z[d], n[d]} !== 4'b0000) begin
         fails++; $display("FAIL flush_outputs dut%0d: got %h/%b want 0/0000", d, s[d], {co[d], ov[d], z[d], n[d]});
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid[d] === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         fails++; $display("FAIL flush_ghost dut%0d: got %0d valid cycles want 0", d, seen);
      end
      @(negedge clk);
      in_valid[d] = 1'b1;
      a[d] = 32'h0000FFFF; b[d] = 32'h00000001; ctr[d] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid[d] = 1'b0;
      lat = 0;
      while (out_valid[d] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      model(wid(d), 32'h0000FFFF, 32'h00000001, 1'b0, es, ef);
      $display("dut%0d post-flush op -> s=%h lat=%0d", d, s[d], lat);
      checks++;
      if (lat != lat_of(d) || s[d] !== es || {co[d], ov[d], z[d], n[d]} !== ef) begin
         fails++; $display("FAIL flush_new_op dut%0d: got lat=%0d %h/%b want lat=%0d %h/%b", d, lat, s[d],
                           {co[d], ov[d], z[d], n[d]}, lat_of(d), es, ef);
      end
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         rst_n[d] = 1'b0; in_valid[d] = 1'b0; out_ready[d] = 1'b1;
         a[d] = '0; b[d] = '0; ctr[d] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;
      #1;
      for (int d = 0; d < ND; d++) test_reset(d);
      for (int d = 0; d < ND; d++) begin
         test_directed(d);
         test_back_to_back(d);
      end
      test_flush(0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
